// File: rtl/cache_types.sv
// Shared cache-subsystem types: DFP adapter state encoding and default widths.
package cache_types;

  localparam int unsigned DFP_BEAT_WIDTH = 64;
  localparam int unsigned DFP_LINE_WIDTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_CMD,
    READ_DATA,
    RESP
  } dfp_adapter_state_t;

endpackage

// File: rtl/l2_dfp_burst_adapter.sv
// L2 line-request to burst-memory adapter: splits a cacheline write into
// ready-qualified beats and assembles read beats back into a line.
module l2_dfp_burst_adapter
  import cache_types::*;
#(
  parameter int unsigned BEAT_WIDTH = DFP_BEAT_WIDTH,
  parameter int unsigned LINE_WIDTH = DFP_LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam int unsigned BEATS       = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [31:0] LINE_MASK   = ~((32'd1 << OFFSET_BITS) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef logic [BEATS-1:0][BEAT_WIDTH-1:0] line_t;

  dfp_adapter_state_t state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  line_t              wline_q, wline_d;
  line_t              rline_q, rline_d;
  // Set for the cycle right after RESP so the still-held request level is not re-accepted.
  logic               block_q;

  // State, counter, address latch and line buffers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      block_q <= (state_q == RESP);
    end
  end

  // Next-state, datapath updates and command outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wline_d    = wline_q;
    rline_d    = rline_q;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!block_q) begin
          if (dfp_write) begin
            addr_d  = dfp_addr & LINE_MASK;
            wline_d = dfp_wdata;
            cnt_d   = '0;
            state_d = WRITE;
          end else if (dfp_read) begin
            addr_d  = dfp_addr & LINE_MASK;
            state_d = READ_CMD;
          end
        end
      end
      WRITE: begin
        bmem_write = 1'b1;
        bmem_wdata = wline_q[cnt_q];
        if (bmem_ready) begin
          if (cnt_q == LAST_BEAT) state_d = RESP;
          else                    cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      READ_CMD: begin
        bmem_read = 1'b1;
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = READ_DATA;
        end
      end
      READ_DATA: begin
        if (bmem_rvalid) begin
          rline_d[cnt_q] = bmem_rdata;
          if (cnt_q == LAST_BEAT) state_d = RESP;
          else                    cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        dfp_resp = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bmem_addr = addr_q;
  assign dfp_rdata = rline_q;

endmodule

// File: tb/tb_l2_dfp_burst_adapter.sv
// Self-checking bench for l2_dfp_burst_adapter: directed scenarios plus
// randomized line reads/writes against a beat-list reference model.
module tb_l2_dfp_burst_adapter;

  localparam int BW    = 64;
  localparam int LW    = 256;
  localparam int BEATS = LW / BW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   dfp_addr = '0;
  logic          dfp_read = 1'b0;
  logic          dfp_write = 1'b0;
  logic [LW-1:0] dfp_wdata = '0;
  logic [LW-1:0] dfp_rdata;
  logic          dfp_resp;
  logic [31:0]   bmem_addr;
  logic          bmem_read;
  logic          bmem_write;
  logic [BW-1:0] bmem_wdata;
  logic          bmem_ready = 1'b0;
  logic [BW-1:0] bmem_rdata = '0;
  logic          bmem_rvalid = 1'b0;

  int checks = 0;
  int errors = 0;

  l2_dfp_burst_adapter #(.BEAT_WIDTH(BW), .LINE_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_read"}, bmem_read, 1'b0);
    chk({tag, "_write"}, bmem_write, 1'b0);
    chk({tag, "_resp"}, dfp_resp, 1'b0);
  endtask

  // One line write; model expects beat k = bits [k*BW +: BW], one per accepted cycle,
  // and completion BEATS+1 cycles after the request plus one per stalled beat.
  task automatic do_write(input logic [31:0] a, input logic [255:0] wd, input int unsigned stall_pct,
                          input int stall_beat, input int unsigned stall_len,
                          input bit also_read, input bit stale);
    int n = 0, k = 0, stalls = 0, held = 0;
    int unsigned sl = 0;
    bit done = 1'b0;
    logic rdy;
    logic [BW-1:0] exp_beat;
    dfp_addr  = a;
    dfp_wdata = wd;
    dfp_write = 1'b1;
    dfp_read  = also_read;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      chk("wr_no_read", bmem_read, 1'b0);
      if (dfp_resp) begin
        done = 1'b1;
        chk("wr_resp_quiet", bmem_write, 1'b0);
      end else begin
        rdy = 1'b1;
        if (bmem_write) begin
          if (k >= BEATS) begin
            chk("wr_extra_beat", bmem_write, 1'b0);
          end else begin
            exp_beat = wd[k*BW +: BW];
            chk("wr_addr", bmem_addr, a & 32'hFFFF_FFE0);
            chk("wr_data", bmem_wdata, exp_beat);
            if (k == stall_beat) begin
              held++;
              if (sl < stall_len) begin
                rdy = 1'b0;
                sl++;
              end
            end else begin
              rdy = ($urandom_range(99) >= stall_pct);
            end
            if (rdy) k++;
            else     stalls++;
          end
        end
        bmem_ready = rdy;
      end
    end
    chk("wr_done", done, 1'b1);
    chk("wr_beats", k, BEATS);
    chk("wr_latency", n, BEATS + 1 + stalls);
    if (stall_beat >= 0) chk("wr_hold", held, stall_len + 1);
    dfp_write = stale;
    repeat (2) @(negedge clk);
    chk("wr_no_reaccept_w", bmem_write, 1'b0);
    chk("wr_no_reaccept_r", bmem_read, 1'b0);
    dfp_write = 1'b0;
  endtask

  // One line read. In mask mode, bit r of mask drives rvalid r cycles after the
  // command-accept cycle; otherwise ready/rvalid are random, with spurious rvalid
  // while the command is still pending. Optional reset once rst_after beats are in.
  task automatic do_read(input logic [31:0] a, input logic [255:0] line, input logic [15:0] mask,
                         input bit use_mask, input int unsigned stall_pct, input int rst_after,
                         output bit reset_hit);
    int n = 0, k = 0, acc = 0, rd_acc = 0, first_rd = 0;
    bit done = 1'b0;
    logic rdy, rv;
    reset_hit = 1'b0;
    dfp_addr  = a;
    dfp_read  = 1'b1;
    dfp_write = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      chk("rd_no_write", bmem_write, 1'b0);
      if (k == BEATS) begin
        chk("rd_resp", dfp_resp, 1'b1);
        chk("rd_line", dfp_rdata, line);
        bmem_rvalid = 1'b0;
        done = 1'b1;
      end else begin
        chk("rd_resp_early", dfp_resp, 1'b0);
        if (rst_after >= 0 && k == rst_after) begin
          bmem_rvalid = 1'b0;
          rst = 1'b0;
          #1;
          chk("rst_bmem_read", bmem_read, 1'b0);
          chk("rst_bmem_write", bmem_write, 1'b0);
          chk("rst_dfp_resp", dfp_resp, 1'b0);
          chk("rst_bmem_addr", bmem_addr, 32'h0);
          chk("rst_bmem_wdata", bmem_wdata, 64'h0);
          chk("rst_dfp_rdata", dfp_rdata, 256'h0);
          repeat (2) begin
            @(negedge clk);
            chk("rst_no_resp", dfp_resp, 1'b0);
          end
          rst = 1'b1;
          reset_hit = 1'b1;
          return;
        end
        if (bmem_read) begin
          if (first_rd == 0) first_rd = n;
          chk("rd_addr", bmem_addr, a & 32'hFFFF_FFE0);
          chk("rd_cmd_once", rd_acc, 0);
        end
        rdy = use_mask ? 1'b1 : ($urandom_range(99) >= stall_pct);
        rv  = 1'b0;
        if (acc != 0 && n > acc) begin
          if (use_mask) rv = (n - acc < 16) ? mask[n - acc] : 1'b0;
          else          rv = 1'($urandom_range(1));
        end else if (!use_mask) begin
          rv = 1'($urandom_range(1));
        end
        if (rv && acc != 0 && n > acc) begin
          bmem_rdata = line[k*BW +: BW];
          k++;
        end else begin
          bmem_rdata = {$urandom, $urandom};
        end
        if (bmem_read && rdy) begin
          acc = n;
          rd_acc++;
        end
        bmem_rvalid = rv;
        bmem_ready  = rdy;
      end
    end
    chk("rd_done", done, 1'b1);
    chk("rd_cmd_count", rd_acc, 1);
    chk("rd_cmd_latency", first_rd, 1);
    dfp_read = 1'b0;
    bmem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk_quiet("rd_after");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit rh;
    logic [255:0] l0, l1;
    logic [31:0] a0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset_addr", bmem_addr, 32'h0);
    chk("reset_wdata", bmem_wdata, 64'h0);
    chk("reset_rdata", dfp_rdata, 256'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Unstalled write with unaligned address
    do_write(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
             0, -1, 0, 1'b0, 1'b0);

    // Write with the request level left high past completion
    do_write($urandom, rand_line(), 0, -1, 0, 1'b0, 1'b1);

    // Read with gapped rvalid: cycles 2,5,6,9 from request = 1,4,5,8 after command accept
    do_read(32'h8000_0040, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
            16'h0132, 1'b1, 0, -1, rh);

    // Three ready-low cycles in front of beat 1
    do_write(32'h0000_2000, rand_line(), 0, 1, 3, 1'b0, 1'b0);

    // Read and write together: write burst first, then the held read
    a0 = $urandom;
    do_write(a0, rand_line(), 0, -1, 0, 1'b1, 1'b0);
    do_read(a0, rand_line(), 16'h001E, 1'b1, 0, -1, rh);

    // Spurious rvalid in IDLE
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = {$urandom, $urandom};
      @(negedge clk);
      chk_quiet("idle_rvalid");
    end
    bmem_rvalid = 1'b0;

    // Reset after beat 2 of a read, then restart of the still-held read
    a0 = 32'h0000_0F00;
    l0 = rand_line();
    do_read(a0, l0, 16'h001E, 1'b1, 0, 2, rh);
    chk("rst_hit", rh, 1'b1);
    l1 = rand_line();
    do_read(a0, l1, 16'h001E, 1'b1, 0, -1, rh);

    // Randomized traffic
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(1) == 1) do_write($urandom, rand_line(), 25, -1, 0, 1'b0, 1'b0);
      else                        do_read($urandom, rand_line(), 16'h0, 1'b0, 25, -1, rh);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_dfp_burst_adapter.md
L2_DFP_BURST_ADAPTER -- requirements
Module: l2_dfp_burst_adapter

Interface
REQ-001 SHALL have parameter BEAT_WIDTH, default 64: memory-side beat width in bits.
REQ-002 SHALL have parameter LINE_WIDTH, default 256: cacheline width in bits; BEATS = LINE_WIDTH/BEAT_WIDTH (4 at defaults).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL provide the following ports, in this order:
- clk  input  1  sole clock, rising-edge.
- rst  input  1  asynchronous active-low reset.
- dfp_addr  input  32  line address from L2; bits [4:0] ignored.
- dfp_read  input  1  line read request; held high until dfp_resp.
- dfp_write  input  1  line write request; held high until dfp_resp.
- dfp_wdata  input  LINE_WIDTH  line write data; stable while dfp_write is high.
- dfp_rdata  output  LINE_WIDTH  line read data; valid while dfp_resp is high.
- dfp_resp  output  1  single-cycle completion pulse.
- bmem_addr  output  32  burst base address, line-aligned.
- bmem_read  output  1  burst read command.
- bmem_write  output  1  burst write beat valid.
- bmem_wdata  output  BEAT_WIDTH  write beat data.
- bmem_ready  input  1  memory accepts a command or write beat this cycle.
- bmem_rdata  input  BEAT_WIDTH  read beat data.
- bmem_rvalid  input  1  read beat valid.

Function
REQ-005 SHALL implement FSM states IDLE, WRITE, READ_CMD, READ_DATA, RESP.
REQ-006 IDLE: on dfp_write, SHALL latch the line address (bits [4:0] forced to zero) and dfp_wdata, clear the beat counter, and go to WRITE.
REQ-007 IDLE: on dfp_read with dfp_write low, SHALL latch the line address and go to READ_CMD. dfp_write has priority if both are high; the read stays pending because the L2 holds its level.
REQ-008 WRITE: SHALL drive bmem_write=1, bmem_addr=latched address, and bmem_wdata=beat[counter].
- Beat k is bits [k*BEAT_WIDTH +: BEAT_WIDTH], low beat first.
- The counter SHALL advance only when bmem_ready=1.
- bmem_write SHALL stay high through ready=0 stalls, with data held.
REQ-009 WRITE: acceptance of beat BEATS-1 SHALL move the FSM to RESP.
REQ-010 READ_CMD: SHALL hold bmem_read=1 and bmem_addr until bmem_ready=1, then go to READ_DATA with the counter cleared.
- bmem_read SHALL be high for exactly one ready-qualified cycle per line.
REQ-011 READ_DATA: each bmem_rvalid SHALL write bmem_rdata into line-buffer beat[counter] and advance the counter. The beat of index BEATS-1 SHALL move the FSM to RESP.
REQ-012 RESP: SHALL assert dfp_resp for exactly one cycle, then return to IDLE.
- For a read, dfp_rdata SHALL present the complete registered line buffer during the dfp_resp cycle.
- Outside RESP, dfp_rdata is don't-care.
REQ-013 IDLE SHALL NOT accept a new request in the cycle after RESP, so the stale held level is not re-sampled. Minimum inter-request spacing is one IDLE cycle.
REQ-014 bmem_rvalid outside READ_DATA SHALL be ignored: no state change, no buffer write.
REQ-015 bmem_read and bmem_write SHALL never be high in the same cycle. Outside their states, bmem_read, bmem_write and dfp_resp SHALL be 0.
REQ-016 The beat counter SHALL be $clog2(BEATS) bits wide. It never wraps within a line and is only cleared on entry to WRITE or READ_DATA.
REQ-017 Latency with zero-stall memory:
- write: dfp_resp BEATS+1 cycles after the IDLE acceptance edge.
- read: dfp_resp one cycle after the last rvalid.

Reset
REQ-018 While rst=0, SHALL asynchronously force:
- state=IDLE, counter=0;
- dfp_resp, bmem_read, bmem_write = 0;
- bmem_addr=0, bmem_wdata=0, dfp_rdata=0.
REQ-019 Reset mid-burst SHALL abandon the transaction without any dfp_resp. After release, the FSM restarts from IDLE and re-samples the held dfp request.

Structure
REQ-020 The FSM state enum (dfp_adapter_state_t) and BEAT_WIDTH/LINE_WIDTH defaults SHALL live in the shared cache_types package.
REQ-021 The block SHALL be a single module with no sub-modules. Line buffer, address latch and counter SHALL be flops in this module.

Verification
REQ-022 Write, no stalls: dfp_write, addr 0x0000_1234, wdata beats 0x11..,0x22..,0x33..,0x44.. -> bmem_addr=0x0000_1220, four consecutive beats in that order, dfp_resp 5 cycles after acceptance.
REQ-023 Read with gaps: dfp_read addr 0x8000_0040, rvalid on cycles 2,5,6,9 with 0xA..,0xB..,0xC..,0xD.. -> one bmem_read cycle; dfp_rdata={D,C,B,A}; dfp_resp 1 cycle after the 4th beat.
REQ-024 Ready stalls: bmem_ready low 3 cycles before beat 1 -> beat 1 held on bmem_wdata for 4 cycles; no beat skipped or duplicated.
REQ-025 Simultaneous dfp_read=dfp_write=1 in IDLE -> write burst first, then read burst, two separate dfp_resp pulses.
REQ-026 Spurious rvalid in IDLE, then rst=0 asserted after beat 2 of a read -> ignored in IDLE; on reset, all outputs 0 immediately; no dfp_resp; clean restart afterwards.
